// File: rtl/bin_gray_counter.sv
// Up/down binary counter with a registered Gray-code image of the count.
// bin and gray are loaded on the same edge from the same next value, so the
// two outputs never disagree, and gray moves by exactly one bit per count
// step (including across a wrap). Priority each cycle: rst > load > en > hold.
module bin_gray_counter #(
  parameter int WIDTH = 4  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Boundary detectors for roll-over (all ones going up) and roll-under (zero going down).
  logic at_max;
  logic at_min;
  assign at_max = &bin_q;
  assign at_min = ~|bin_q;

  // Next binary value and wrap flag; load beats counting, wrap only on a real count step.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + ONE;
        wrap_d = at_max;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = at_min;
      end
    end
  end

  // Gray encode the *next* value so the Gray register lands on the same edge as bin.
  // The MSB passes straight through; every other bit is the XOR of a bit and its upper neighbour.
  assign gray_d[WIDTH-1] = bin_d[WIDTH-1];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray_enc
      assign gray_d[gi] = bin_d[gi] ^ bin_d[gi+1];
    end
  endgenerate

  // State registers; synchronous reset clears everything and overrides load/en.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_gray_counter.sv
// Directed table of {inputs, expected outputs} for WIDTH=4, followed by a
// random enable/direction/load run checked against a small reference model.
module tb_bin_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  bin_gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic e, logic u, logic l,
                              logic [W-1:0] lb, logic [W-1:0] eb,
                              logic [W-1:0] eg, logic ew);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.up_dn = u; v.load = l;
    v.load_bin = lb; v.exp_bin = eb; v.exp_gray = eg; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic e, logic u, logic l, logic [W-1:0] lb);
    rst = r; en = e; up_dn = u; load = l; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] up_gray [16];
  logic [W-1:0] prev_gray;
  logic [W-1:0] m_bin;
  logic         m_wrap;
  logic         r_en, r_up, r_ld;
  logic [W-1:0] r_lb;

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_bin = '0;

    // Gray sequence for counting up from 1 through the wrap back to 0.
    up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    // Reset held two cycles with en=1.
    vecs.push_back(mk("rst",   1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("rst",   1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0));
    // Count up 16 steps through the wrap.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk("up", 0, 1, 1, 0, 4'h0, 4'((i + 1) % 16), up_gray[i], i == 15));
    // Load all ones, then wrap up, then hold.
    vecs.push_back(mk("load",  0, 0, 1, 1, 4'hF, 4'hF, 4'b1000, 0));
    vecs.push_back(mk("upwrap",0, 1, 1, 0, 4'h0, 4'h0, 4'b0000, 1));
    vecs.push_back(mk("hold",  0, 0, 1, 0, 4'h0, 4'h0, 4'b0000, 0));
    // Count down through the wrap.
    vecs.push_back(mk("dnwrap",0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1));
    vecs.push_back(mk("dn",    0, 1, 0, 0, 4'h0, 4'hE, 4'b1001, 0));
    // Load beats en; rst beats load and en.
    vecs.push_back(mk("ldpri", 0, 1, 0, 1, 4'h5, 4'h5, 4'b0111, 0));
    vecs.push_back(mk("rstpri",1, 1, 1, 1, 4'hA, 4'h0, 4'h0, 0));
    // Back-to-back wraps with direction flips: one pulse per wrap, no stretching.
    vecs.push_back(mk("bb_dn", 0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1));
    vecs.push_back(mk("bb_up", 0, 1, 1, 0, 4'h0, 4'h0, 4'b0000, 1));
    vecs.push_back(mk("bb_dn", 0, 1, 0, 0, 4'h0, 4'hF, 4'b1000, 1));
    vecs.push_back(mk("bb_dn", 0, 1, 0, 0, 4'h0, 4'hE, 4'b1001, 0));
    // Load with en=1 while at a wrap boundary: no wrap pulse.
    vecs.push_back(mk("ldbnd", 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("ldnow", 0, 1, 0, 1, 4'h3, 4'h3, 4'b0010, 0));

    prev_gray = '0;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_bin);
      check({vecs[i].name, ".bin"},  i, 32'(bin),  32'(vecs[i].exp_bin));
      check({vecs[i].name, ".gray"}, i, 32'(gray), 32'(vecs[i].exp_gray));
      check({vecs[i].name, ".wrap"}, i, 32'(wrap), 32'(vecs[i].exp_wrap));
      if (i > 0 && !vecs[i].rst && !vecs[i].load && vecs[i].en)
        check({vecs[i].name, ".onebit"}, i, 32'($countones(gray ^ prev_gray)), 32'd1);
      $display("vec %0d %s: bin=%b gray=%b wrap=%b", i, vecs[i].name, bin, gray, wrap);
      prev_gray = gray;
    end

    // Mid-count reset clears outputs immediately after the edge.
    drive(0, 1, 1, 0, 4'h0);
    drive(0, 1, 1, 0, 4'h0);
    drive(1, 1, 1, 0, 4'h0);
    check("midrst.bin",  0, 32'(bin),  32'd0);
    check("midrst.gray", 0, 32'(gray), 32'd0);
    check("midrst.wrap", 0, 32'(wrap), 32'd0);
    $display("midrst: bin=%b gray=%b wrap=%b", bin, gray, wrap);

    // Random enable/direction with occasional loads against a reference model.
    m_bin = '0;
    for (int c = 0; c < 1000; c++) begin
      r_en = 1'($urandom_range(0, 3) != 0);
      r_up = 1'($urandom_range(0, 1));
      r_ld = 1'($urandom_range(0, 15) == 0);
      r_lb = W'($urandom);
      m_wrap = 1'b0;
      if (r_ld) begin
        m_bin = r_lb;
      end else if (r_en) begin
        if (r_up) begin
          m_wrap = (m_bin == 4'hF);
          m_bin  = m_bin + 4'h1;
        end else begin
          m_wrap = (m_bin == 4'h0);
          m_bin  = m_bin - 4'h1;
        end
      end
      prev_gray = gray;
      drive(0, r_en, r_up, r_ld, r_lb);
      check("rnd.bin",  c, 32'(bin),  32'(m_bin));
      check("rnd.gray", c, 32'(gray), 32'(m_bin ^ (m_bin >> 1)));
      check("rnd.inv",  c, 32'(gray), 32'(bin ^ (bin >> 1)));
      check("rnd.wrap", c, 32'(wrap), 32'(m_wrap));
      if (!r_ld && r_en)
        check("rnd.onebit", c, 32'($countones(gray ^ prev_gray)), 32'd1);
      $display("rnd %0d: en=%b up=%b ld=%b bin=%b gray=%b wrap=%b",
               c, r_en, r_up, r_ld, bin, gray, wrap);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
